// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit path: ALU opcodes, sequencer states, default width.
package vend_pkg;

  localparam int DEF_WIDTH = 5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD_EX = 2'd1,
    ST_SUB_EX = 2'd2,
    ST_REFUND = 2'd3
  } state_t;

endpackage

// File: rtl/vend_credit_seq.sv
// Credit sequencer: drives the shared external ALU to add coins and charge selections,
// strobes vend/reject and hands back change through a valid/ack handshake.
module vend_credit_seq
  import vend_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MAX_CREDIT  = 31,
  parameter int AUTO_CHANGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_value,
  output logic             coin_ready,
  input  logic             sel_valid,
  input  logic [WIDTH-1:0] price,
  output logic             sel_ready,
  input  logic             cancel,
  input  logic             change_ack,
  output logic             vend_pulse,
  output logic             reject_pulse,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_value,
  output logic [WIDTH-1:0] credit,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero
);

  localparam logic [WIDTH:0] LP_MAX = (WIDTH + 1)'(MAX_CREDIT);

  state_t           r_state;
  logic [WIDTH-1:0] r_credit;
  logic [WIDTH-1:0] r_operand;
  logic             r_vend;
  logic             r_reject;
  logic             r_change_valid;
  logic [WIDTH-1:0] r_change_value;

  logic w_idle;
  logic w_over;

  assign w_idle = (r_state == ST_IDLE);
  // Carry covers a sum beyond the register; the compare covers a ceiling below full scale.
  assign w_over = alu_carry || ({1'b0, alu_result} > LP_MAX);

  assign coin_ready   = w_idle;
  assign sel_ready    = w_idle;
  assign busy         = !w_idle;
  assign credit       = r_credit;
  assign vend_pulse   = r_vend;
  assign reject_pulse = r_reject;
  assign change_valid = r_change_valid;
  assign change_value = r_change_value;

  assign alu_a  = r_credit;
  assign alu_b  = (r_state == ST_ADD_EX || r_state == ST_SUB_EX) ? r_operand : '0;
  assign alu_op = (r_state == ST_SUB_EX) ? OP_SUB : OP_ADD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_operand      <= '0;
      r_vend         <= 1'b0;
      r_reject       <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_value <= '0;
    end else begin
      r_vend   <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Priority: cancel, then selection, then coin; losers stay pending.
          if (cancel) begin
            if (r_credit != '0) begin
              r_state        <= ST_REFUND;
              r_change_valid <= 1'b1;
              r_change_value <= r_credit;
            end
          end else if (sel_valid) begin
            r_operand <= price;
            r_state   <= ST_SUB_EX;
          end else if (coin_valid) begin
            r_operand <= coin_value;
            r_state   <= ST_ADD_EX;
          end
        end
        ST_ADD_EX: begin
          if (w_over) begin
            r_reject <= 1'b1;
          end else begin
            r_credit <= alu_result;
          end
          r_state <= ST_IDLE;
        end
        ST_SUB_EX: begin
          if (alu_carry) begin
            r_reject <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_credit <= alu_result;
            r_vend   <= 1'b1;
            if (AUTO_CHANGE != 0 && !alu_zero) begin
              r_state        <= ST_REFUND;
              r_change_valid <= 1'b1;
              r_change_value <= alu_result;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_REFUND: begin
          if (change_ack) begin
            r_credit       <= '0;
            r_change_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_seq.sv
// Bench for vend_credit_seq: two instances (default, and MAX_CREDIT=25 / AUTO_CHANGE=0), each
// with its own behavioural ALU, driven transaction by transaction against a credit-ledger model.
module tb_vend_credit_seq;

  localparam int W = 5;

  logic         clk;
  logic         rst_n        [2];
  logic         coin_valid   [2];
  logic [W-1:0] coin_value   [2];
  logic         coin_ready   [2];
  logic         sel_valid    [2];
  logic [W-1:0] price        [2];
  logic         sel_ready    [2];
  logic         cancel       [2];
  logic         change_ack   [2];
  logic         vend_pulse   [2];
  logic         reject_pulse [2];
  logic         change_valid [2];
  logic [W-1:0] change_value [2];
  logic [W-1:0] credit       [2];
  logic         busy         [2];
  logic [W-1:0] alu_a        [2];
  logic [W-1:0] alu_b        [2];
  logic [2:0]   alu_op       [2];
  logic [W-1:0] alu_result   [2];
  logic         alu_carry    [2];
  logic         alu_zero     [2];

  int n_cmp = 0;
  int n_err = 0;
  int m_credit [2];
  int hold_req = -1;

  function automatic logic [W:0] alu_calc(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {(a < b), W'(a - b)};
      3'b101:  r = {1'b0, ~a};
      default: r = '0;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    assign {alu_carry[gi], alu_result[gi]} = alu_calc(alu_op[gi], alu_a[gi], alu_b[gi]);
    assign alu_zero[gi] = (alu_result[gi] == '0);

    vend_credit_seq #(
      .WIDTH      (W),
      .MAX_CREDIT (gi == 0 ? 31 : 25),
      .AUTO_CHANGE(gi == 0 ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[gi]),
      .coin_valid  (coin_valid[gi]),
      .coin_value  (coin_value[gi]),
      .coin_ready  (coin_ready[gi]),
      .sel_valid   (sel_valid[gi]),
      .price       (price[gi]),
      .sel_ready   (sel_ready[gi]),
      .cancel      (cancel[gi]),
      .change_ack  (change_ack[gi]),
      .vend_pulse  (vend_pulse[gi]),
      .reject_pulse(reject_pulse[gi]),
      .change_valid(change_valid[gi]),
      .change_value(change_value[gi]),
      .credit      (credit[gi]),
      .busy        (busy[gi]),
      .alu_a       (alu_a[gi]),
      .alu_b       (alu_b[gi]),
      .alu_op      (alu_op[gi]),
      .alu_result  (alu_result[gi]),
      .alu_carry   (alu_carry[gi]),
      .alu_zero    (alu_zero[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int max_credit(input int k);
    return (k == 0) ? 31 : 25;
  endfunction

  function automatic bit auto_change(input int k);
    return (k == 0);
  endfunction

  task automatic check_val(input int k, input string tag, input int unsigned got,
                           input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0d, expected %0d (t=%0t)", k, tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sits in change hand-back for a number of cycles, then acknowledges.
  task automatic do_refund(input int k);
    int hold;
    int val;
    hold = (hold_req >= 0) ? hold_req : int'($urandom_range(0, 3));
    val  = m_credit[k];
    for (int i = 0; i < hold; i++) begin
      next_cycle();
      check_val(k, "hold_cv", change_valid[k], 1);
      check_val(k, "hold_cval", change_value[k], val);
      check_val(k, "hold_busy", busy[k], 1);
      check_val(k, "hold_credit", credit[k], m_credit[k]);
      check_val(k, "hold_vend", vend_pulse[k], 0);
      check_val(k, "hold_rej", reject_pulse[k], 0);
    end
    change_ack[k] = 1'b1;
    next_cycle();
    change_ack[k] = 1'b0;
    m_credit[k] = 0;
    check_val(k, "ack_cv", change_valid[k], 0);
    check_val(k, "ack_credit", credit[k], 0);
    check_val(k, "ack_busy", busy[k], 0);
    check_val(k, "ack_vend", vend_pulse[k], 0);
    $display("u%0d refund %0d collected after %0d hold cycles", k, val, hold);
  endtask

  // Presents any mix of cancel/sel/coin at once and serves them in priority order.
  task automatic run_req(input int k, input bit c, input bit s, input int p, input bit n,
                         input int v, input bit ack_noise);
    int  w;
    bit  pend;
    pend = 1'b0;
    check_val(k, "start_idle", busy[k], 0);
    cancel[k]     = c;
    sel_valid[k]  = s;
    price[k]      = W'(p);
    coin_valid[k] = n;
    coin_value[k] = W'(v);
    change_ack[k] = ack_noise;
    while (cancel[k] || sel_valid[k] || coin_valid[k]) begin
      w = cancel[k] ? 0 : (sel_valid[k] ? 1 : 2);
      next_cycle();
      change_ack[k] = 1'b0;
      check_val(k, "prev_vend_low", vend_pulse[k], 0);
      check_val(k, "prev_rej_low", reject_pulse[k], 0);
      if (w == 0) begin
        cancel[k] = 1'b0;
        pend = 1'b0;
        $display("u%0d cancel at credit %0d", k, m_credit[k]);
        if (m_credit[k] == 0) begin
          check_val(k, "cancel0_busy", busy[k], 0);
          check_val(k, "cancel0_credit", credit[k], 0);
        end else begin
          check_val(k, "cancel_busy", busy[k], 1);
          check_val(k, "cancel_cv", change_valid[k], 1);
          check_val(k, "cancel_cval", change_value[k], m_credit[k]);
          do_refund(k);
        end
      end else if (w == 1) begin
        sel_valid[k] = 1'b0;
        check_val(k, "sub_busy", busy[k], 1);
        check_val(k, "sub_ready", sel_ready[k], 0);
        check_val(k, "sub_op", alu_op[k], 1);
        check_val(k, "sub_a", alu_a[k], m_credit[k]);
        check_val(k, "sub_b", alu_b[k], p);
        next_cycle();
        $display("u%0d select price %0d at credit %0d", k, p, m_credit[k]);
        if (p > m_credit[k]) begin
          check_val(k, "short_rej", reject_pulse[k], 1);
          check_val(k, "short_vend", vend_pulse[k], 0);
          check_val(k, "short_credit", credit[k], m_credit[k]);
          check_val(k, "short_busy", busy[k], 0);
        end else begin
          m_credit[k] = m_credit[k] - p;
          check_val(k, "vend_pulse", vend_pulse[k], 1);
          check_val(k, "vend_rej", reject_pulse[k], 0);
          check_val(k, "vend_credit", credit[k], m_credit[k]);
          if (auto_change(k) && m_credit[k] != 0) begin
            check_val(k, "vend_cv", change_valid[k], 1);
            check_val(k, "vend_cval", change_value[k], m_credit[k]);
            check_val(k, "vend_busy", busy[k], 1);
            do_refund(k);
          end else begin
            check_val(k, "vend_cv", change_valid[k], 0);
            check_val(k, "vend_busy", busy[k], 0);
          end
        end
        pend = 1'b1;
      end else begin
        coin_valid[k] = 1'b0;
        check_val(k, "add_busy", busy[k], 1);
        check_val(k, "add_ready", coin_ready[k], 0);
        check_val(k, "add_op", alu_op[k], 0);
        check_val(k, "add_a", alu_a[k], m_credit[k]);
        check_val(k, "add_b", alu_b[k], v);
        next_cycle();
        $display("u%0d coin %0d at credit %0d", k, v, m_credit[k]);
        if (m_credit[k] + v > max_credit(k)) begin
          check_val(k, "ovf_rej", reject_pulse[k], 1);
        end else begin
          m_credit[k] = m_credit[k] + v;
          check_val(k, "coin_rej", reject_pulse[k], 0);
        end
        check_val(k, "coin_credit", credit[k], m_credit[k]);
        check_val(k, "coin_vend", vend_pulse[k], 0);
        check_val(k, "coin_busy", busy[k], 0);
        pend = 1'b1;
      end
    end
    if (pend) begin
      next_cycle();
      check_val(k, "end_vend_low", vend_pulse[k], 0);
      check_val(k, "end_rej_low", reject_pulse[k], 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; coin_valid[k] = 1'b0; coin_value[k] = '0; sel_valid[k] = 1'b0;
      price[k] = '0; cancel[k] = 1'b0; change_ack[k] = 1'b0; m_credit[k] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val(k, "rst_credit", credit[k], 0);
      check_val(k, "rst_cv", change_valid[k], 0);
      check_val(k, "rst_cval", change_value[k], 0);
      check_val(k, "rst_vend", vend_pulse[k], 0);
      check_val(k, "rst_rej", reject_pulse[k], 0);
      check_val(k, "rst_busy", busy[k], 0);
      check_val(k, "rst_ready", coin_ready[k], 1);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);

    // Accumulate, vend with change held three cycles.
    run_req(0, 0, 0, 0, 1, 5, 0);
    run_req(0, 0, 0, 0, 1, 3, 0);
    hold_req = 3;
    run_req(0, 0, 1, 6, 0, 0, 0);
    hold_req = -1;
    // Overflow by carry, insufficient funds, exact price.
    run_req(0, 0, 0, 0, 1, 20, 0);
    run_req(0, 0, 0, 0, 1, 15, 0);
    run_req(0, 0, 1, 25, 0, 0, 0);
    run_req(0, 0, 1, 20, 0, 0, 1);
    // Simultaneous cancel/sel/coin at credit 10, then sel+coin at credit 10.
    run_req(0, 0, 0, 0, 1, 10, 0);
    run_req(0, 1, 1, 4, 1, 5, 0);
    run_req(0, 1, 0, 0, 0, 0, 0);
    run_req(0, 0, 0, 0, 1, 10, 0);
    run_req(0, 0, 1, 4, 1, 5, 0);
    run_req(0, 0, 1, 0, 0, 0, 0);
    run_req(0, 1, 0, 0, 0, 0, 0);
    run_req(0, 1, 0, 0, 0, 0, 0);
    run_req(0, 0, 0, 0, 1, 0, 0);

    // Lower ceiling, no auto change.
    run_req(1, 0, 0, 0, 1, 20, 0);
    run_req(1, 0, 0, 0, 1, 6, 0);
    run_req(1, 0, 0, 0, 1, 5, 0);
    run_req(1, 1, 0, 0, 0, 0, 0);
    run_req(1, 0, 0, 0, 1, 10, 0);
    run_req(1, 0, 1, 4, 1, 5, 0);
    run_req(1, 0, 1, 11, 0, 0, 0);

    // Asynchronous reset in the middle of a refund.
    run_req(0, 0, 0, 0, 1, 9, 0);
    cancel[0] = 1'b1;
    next_cycle();
    cancel[0] = 1'b0;
    check_val(0, "prerst_cv", change_valid[0], 1);
    check_val(0, "prerst_cval", change_value[0], 9);
    #2 rst_n[0] = 1'b0;
    #1;
    check_val(0, "arst_cv", change_valid[0], 0);
    check_val(0, "arst_credit", credit[0], 0);
    check_val(0, "arst_busy", busy[0], 0);
    $display("u0 async reset during refund of 9");
    m_credit[0] = 0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    run_req(0, 0, 0, 0, 1, 2, 0);

    // Random mixed traffic on both instances.
    for (int t = 0; t < 240; t++) begin
      int  k;
      bit  c, s, n;
      int  p, v;
      k = int'($urandom_range(0, 1));
      c = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      n = !s || ($urandom_range(0, 1) == 1);
      p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 15));
      v = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
      run_req(k, c, s, p, n, v, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
